bcd_serial_add_ctrl: RTL

BCD_SERIAL_ADD_CTRL -- requirements
Module: bcd_serial_add_ctrl

---
 rtl/bcd_serial_add_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/bcd_serial_add_ctrl.sv
// Serial BCD adder controller: one digit per cycle through an external one-digit adder.
// Latency DIGITS+1 edges to done (1 on an invalid digit); no backpressure, start ignored while busy.
module bcd_serial_add_ctrl #(
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   a,
   input  logic [4*DIGITS-1:0]   b,
   input  logic                  cin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   sum,
   output logic                  cout,
   output logic                  err,
   output logic [3:0]            dig_a,
   output logic [3:0]            dig_b,
   output logic                  dig_cin,
   input  logic [3:0]            dig_s,
   input  logic                  dig_cout
);

   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

   typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

   state_t              state, state_nxt;
   logic [4*DIGITS-1:0] a_r, b_r;
   logic [IW-1:0]       idx;
   logic                carry;
   logic                bad_digit;

   // Checked on the live inputs so a bad operand is rejected at the accepting edge.
   always_comb begin
      bad_digit = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9)
            bad_digit = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = bad_digit ? DONE : ADD;
         ADD:     if (idx == LAST) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

   always_comb begin
      dig_a   = 4'd0;
      dig_b   = 4'd0;
      dig_cin = 1'b0;
      if (state == ADD) begin
         dig_cin = carry;
         for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
               dig_a = a_r[4*i +: 4];
               dig_b = b_r[4*i +: 4];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_r   <= '0;
         b_r   <= '0;
         idx   <= '0;
         carry <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
         err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_r   <= a;
                  b_r   <= b;
                  carry <= cin;
                  idx   <= '0;
                  sum   <= '0;
                  cout  <= 1'b0;
                  err   <= bad_digit;
               end
            end
            ADD: begin
               for (int i = 0; i < DIGITS; i++) begin
                  if (idx == IW'(i))
                     sum[4*i +: 4] <= dig_s;
               end
               carry <= dig_cout;
               // idx parks on the last digit rather than wrapping.
               if (idx == LAST)
                  cout <= dig_cout;
               else
                  idx <= idx + IW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule
